mouse_cursor_tracker: RTL and testbench

Consumes the 16-bit software-written mouse X/Y position registers and the mouse button register, and turns them into a tear-free, screen-clamped cursor position.
- Position and buttons are sampled once per frame at the vsync falling edge.
- Produces a one-cycle "moved" pulse and per-button click pulses.
- Generates a registered cursor overlay code for the VGA colour mapper from the current draw_x/draw_y.
- Sits between the PIO output registers and the VGA colour mapper, in the VGA pixel clock domain.

---
 rtl/mouse_cursor_tracker.sv | 120 ++++++++++++
 tb/tb_mouse_cursor_tracker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor_tracker.sv
// Mouse cursor tracker: samples the PIO mouse position and buttons once per frame
// at the vsync falling edge, clamps the position to the screen and drives a cursor overlay code.
module mouse_cursor_tracker #(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned CURSOR_W = 16,
  parameter int unsigned CURSOR_H = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mouse_x,
  input  logic [15:0] mouse_y,
  input  logic [2:0]  mouse_btn,
  input  logic        vs_n,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  output logic [9:0]  cursor_x,
  output logic [9:0]  cursor_y,
  output logic        moved,
  output logic [2:0]  click,
  output logic [1:0]  cursor_code
);

  localparam int unsigned MAX_X = H_RES - CURSOR_W;
  localparam int unsigned MAX_Y = V_RES - CURSOR_H;
  localparam logic signed [15:0] MAX_X_S = 16'(MAX_X);
  localparam logic signed [15:0] MAX_Y_S = 16'(MAX_Y);
  localparam logic [9:0] CENTRE_X = 10'(MAX_X / 2);
  localparam logic [9:0] CENTRE_Y = 10'(MAX_Y / 2);
  localparam logic [10:0] SPAN_X = 11'(CURSOR_W - 1);
  localparam logic [10:0] SPAN_Y = 11'(CURSOR_H - 1);

  logic        r_vs_n_d;
  logic [2:0]  r_btn_prev;
  logic [9:0]  r_cursor_x;
  logic [9:0]  r_cursor_y;
  logic        r_moved;
  logic [2:0]  r_click;
  logic [1:0]  r_cursor_code;

  logic        w_tick;
  logic [9:0]  w_new_x;
  logic [9:0]  w_new_y;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_x_lo;
  logic [10:0] w_x_hi;
  logic [10:0] w_y_lo;
  logic [10:0] w_y_hi;
  logic        w_in;
  logic        w_edge;
  logic [1:0]  w_code;

  assign w_tick = r_vs_n_d & ~vs_n;

  // Signed clamp of the software position into the visible cursor range
  always_comb begin
    w_new_x = mouse_x[9:0];
    if (mouse_x[15])
      w_new_x = '0;
    else if ($signed(mouse_x) > MAX_X_S)
      w_new_x = 10'(MAX_X);

    w_new_y = mouse_y[9:0];
    if (mouse_y[15])
      w_new_y = '0;
    else if ($signed(mouse_y) > MAX_Y_S)
      w_new_y = 10'(MAX_Y);
  end

  // Overlay hit test, widened to 11 bits so the far edge never wraps
  always_comb begin
    w_dx   = {1'b0, draw_x};
    w_dy   = {1'b0, draw_y};
    w_x_lo = {1'b0, r_cursor_x};
    w_y_lo = {1'b0, r_cursor_y};
    w_x_hi = w_x_lo + SPAN_X;
    w_y_hi = w_y_lo + SPAN_Y;
    w_in   = (w_dx >= w_x_lo) && (w_dx <= w_x_hi) &&
             (w_dy >= w_y_lo) && (w_dy <= w_y_hi);
    w_edge = w_in && ((w_dx == w_x_lo) || (w_dx == w_x_hi) ||
                      (w_dy == w_y_lo) || (w_dy == w_y_hi));
    w_code = 2'd0;
    if (w_edge)
      w_code = 2'd1;
    else if (w_in)
      w_code = 2'd2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_n_d      <= 1'b1;
      r_btn_prev    <= '0;
      r_cursor_x    <= CENTRE_X;
      r_cursor_y    <= CENTRE_Y;
      r_moved       <= 1'b0;
      r_click       <= '0;
      r_cursor_code <= '0;
    end else begin
      r_vs_n_d      <= vs_n;
      r_cursor_code <= w_code;
      r_moved       <= 1'b0;
      r_click       <= '0;
      if (w_tick) begin
        r_cursor_x <= w_new_x;
        r_cursor_y <= w_new_y;
        r_moved    <= (w_new_x != r_cursor_x) || (w_new_y != r_cursor_y);
        r_click    <= mouse_btn & ~r_btn_prev;
        r_btn_prev <= mouse_btn;
      end
    end
  end

  assign cursor_x    = r_cursor_x;
  assign cursor_y    = r_cursor_y;
  assign moved       = r_moved;
  assign click       = r_click;
  assign cursor_code = r_cursor_code;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: directed scenarios plus randomized frames,
// checked each cycle against a frame-level behavioural model.
module tb_mouse_cursor_tracker;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int CW    = 16;
  localparam int CH    = 16;
  localparam int MAXX  = H_RES - CW;
  localparam int MAXY  = V_RES - CH;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mouse_x;
  logic [15:0] mouse_y;
  logic [2:0]  mouse_btn;
  logic        vs_n;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [9:0]  cursor_x;
  logic [9:0]  cursor_y;
  logic        moved;
  logic [2:0]  click;
  logic [1:0]  cursor_code;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_vs_prev, m_btn_prev, m_cx, m_cy, m_moved, m_click, m_code;

  always #5 clk = ~clk;

  mouse_cursor_tracker #(
    .H_RES(H_RES), .V_RES(V_RES), .CURSOR_W(CW), .CURSOR_H(CH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .mouse_btn  (mouse_btn),
    .vs_n       (vs_n),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .moved      (moved),
    .click      (click),
    .cursor_code(cursor_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input logic [15:0] v, input int hi);
    int s;
    s = int'($signed(v));
    if (s < 0) return 0;
    if (s > hi) return hi;
    return s;
  endfunction

  function automatic int overlay(input int dx, input int dy, input int cx, input int cy);
    bit inside_c, on_edge;
    inside_c = dx >= cx && dx < cx + CW && dy >= cy && dy < cy + CH;
    on_edge  = inside_c && (dx == cx || dx == cx + CW - 1 || dy == cy || dy == cy + CH - 1);
    return on_edge ? 1 : (inside_c ? 2 : 0);
  endfunction

  task automatic model_reset();
    m_vs_prev  = 1;
    m_btn_prev = 0;
    m_cx       = (H_RES - CW) / 2;
    m_cy       = (V_RES - CH) / 2;
    m_moved    = 0;
    m_click    = 0;
    m_code     = 0;
  endtask

  task automatic check_all();
    check("cursor_x", 32'(cursor_x), 32'(m_cx));
    check("cursor_y", 32'(cursor_y), 32'(m_cy));
    check("moved", 32'(moved), 32'(m_moved));
    check("click", 32'(click), 32'(m_click));
    check("cursor_code", 32'(cursor_code), 32'(m_code));
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs
  task automatic step(input logic v, input logic [15:0] mx, input logic [15:0] my,
                      input logic [2:0] b, input int dx, input int dy);
    int nx, ny;
    @(negedge clk);
    vs_n = v; mouse_x = mx; mouse_y = my; mouse_btn = b;
    draw_x = 10'(dx); draw_y = 10'(dy);
    m_code = overlay(dx, dy, m_cx, m_cy);
    if (m_vs_prev == 1 && v == 1'b0) begin
      nx = clamp(mx, MAXX);
      ny = clamp(my, MAXY);
      m_moved = (nx != m_cx || ny != m_cy) ? 1 : 0;
      m_click = int'(b) & ~m_btn_prev & 7;
      m_btn_prev = int'(b);
      m_cx = nx;
      m_cy = ny;
    end else begin
      m_moved = 0;
      m_click = 0;
    end
    m_vs_prev = int'(v);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic frame(input logic [15:0] mx, input logic [15:0] my, input logic [2:0] b);
    step(1'b1, mx, my, b, 0, 0);
    step(1'b0, mx, my, b, 0, 0);
  endtask

  initial begin
    int r, mx, my;
    reset_n = 1'b0; vs_n = 1'b1; mouse_x = '0; mouse_y = '0; mouse_btn = '0;
    draw_x = '0; draw_y = '0;
    model_reset();
    #12;
    check("rst_cursor_x", 32'(cursor_x), 32'd312);
    check("rst_cursor_y", 32'(cursor_y), 32'd232);
    check("rst_moved", 32'(moved), 32'd0);
    check("rst_click", 32'(click), 32'd0);
    check("rst_code", 32'(cursor_code), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // No tick: sweeping the position must not move the cursor
    for (int i = 0; i < 6; i++) step(1'b1, 16'(i * 150), 16'(i * 90), 3'b000, 0, 0);
    check("hold_x", 32'(cursor_x), 32'd312);
    check("hold_moved", 32'(moved), 32'd0);

    frame(16'd100, 16'd50, 3'b000);
    check("move_x", 32'(cursor_x), 32'd100);
    check("move_y", 32'(cursor_y), 32'd50);
    check("move_pulse", 32'(moved), 32'd1);
    step(1'b0, 16'd100, 16'd50, 3'b000, 0, 0);
    check("move_width", 32'(moved), 32'd0);
    step(1'b0, 16'd100, 16'd50, 3'b000, 0, 0);
    frame(16'd100, 16'd50, 3'b000);
    check("same_pos_moved", 32'(moved), 32'd0);

    frame(16'hFFFB, 16'd1000, 3'b000);
    check("clamp_neg_x", 32'(cursor_x), 32'd0);
    check("clamp_big_y", 32'(cursor_y), 32'd464);
    frame(16'd700, 16'd50, 3'b000);
    check("clamp_big_x", 32'(cursor_x), 32'd624);

    frame(16'd100, 16'd50, 3'b001);
    check("click_left", 32'(click), 32'd1);
    step(1'b0, 16'd100, 16'd50, 3'b001, 0, 0);
    check("click_width", 32'(click), 32'd0);
    frame(16'd100, 16'd50, 3'b001);
    check("click_held", 32'(click), 32'd0);
    frame(16'd100, 16'd50, 3'b101);
    check("click_middle", 32'(click), 32'd4);

    // Overlay at cursor (100,50), one cycle latency
    step(1'b1, 16'd100, 16'd50, 3'b101, 100, 50);
    check("ovl_corner", 32'(cursor_code), 32'd1);
    step(1'b1, 16'd100, 16'd50, 3'b101, 107, 57);
    check("ovl_fill", 32'(cursor_code), 32'd2);
    step(1'b1, 16'd100, 16'd50, 3'b101, 115, 65);
    check("ovl_far_corner", 32'(cursor_code), 32'd1);
    step(1'b1, 16'd100, 16'd50, 3'b101, 116, 57);
    check("ovl_right_out", 32'(cursor_code), 32'd0);
    step(1'b1, 16'd100, 16'd50, 3'b101, 99, 50);
    check("ovl_left_out", 32'(cursor_code), 32'd0);

    // Asynchronous reset mid-frame
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_x", 32'(cursor_x), 32'd312);
    check("mid_rst_y", 32'(cursor_y), 32'd232);
    @(negedge clk);
    reset_n = 1'b1;
    frame(16'd312, 16'd232, 3'b000);
    check("post_rst_moved", 32'(moved), 32'd0);

    // Randomized frames, positions and draw coordinates near the cursor
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        mx = int'($urandom_range(0, 900)) - 100;
        my = int'($urandom_range(0, 700)) - 100;
      end else if (r == 3) begin
        mx = int'($urandom);
        my = int'($urandom);
      end else begin
        mx = int'(mouse_x);
        my = int'(mouse_y);
      end
      step(($urandom_range(0, 3) != 0), 16'(mx), 16'(my), 3'($urandom),
           m_cx + int'($urandom_range(0, 19)) - 2,
           m_cy + int'($urandom_range(0, 19)) - 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
